// File: rtl/processor_pkg.sv
// ISA constants, opcode and FSM encodings, and the instruction field layout
// shared by the processor core, its ALU, the RAM port and the RAM.
package processor_pkg;

  localparam int INSTRUCTION_SIZE     = 16;
  localparam int REGISTER_SIZE        = 16;
  localparam int REGISTER_BANK_SIZE   = 16;
  localparam int MEMORY_ADDRESS_WIDTH = 8;
  localparam int MEMORY_DEPTH         = 256;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_MUL = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_SHL = 3'd4,
    OP_SHR = 3'd5,
    OP_LW  = 3'd6,
    OP_SW  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITE_BACK,
    ST_HALT
  } state_e;

  // low carries {rs1, rs2} for register forms, or the absolute address for immediates
  typedef struct packed {
    op_e        op;
    logic       is_imm;
    logic [3:0] rd;
    logic [7:0] low;
  } instr_t;

endpackage

// File: rtl/processor_if.sv
// RAM port bundle. The RAM has a single address line, so the core drives it
// through the read-side modport for both fetch/LW and SW accesses.
interface processor_if;
  import processor_pkg::*;

  logic [MEMORY_ADDRESS_WIDTH-1:0] address;
  logic                            write_enable;
  logic [INSTRUCTION_SIZE-1:0]     write_data;
  logic [INSTRUCTION_SIZE-1:0]     read_data;

  modport master_rd (output address, input read_data);
  modport master_wr (output write_enable, output write_data);
  modport slave     (input address, input write_enable, input write_data, output read_data);
endinterface

// File: rtl/processor_alu.sv
// Register-form ALU: wrap-around add/multiply, bitwise logic and 16-bit rotates.
module processor_alu
  import processor_pkg::*;
(
  input  op_e                      op_i,
  input  logic [REGISTER_SIZE-1:0] src1_i,
  input  logic [REGISTER_SIZE-1:0] src2_i,
  output logic [REGISTER_SIZE-1:0] result_o
);

  logic [2*REGISTER_SIZE-1:0] doubled;
  logic [2*REGISTER_SIZE-1:0] shl_wide;
  logic [2*REGISTER_SIZE-1:0] shr_wide;

  // Shifting the value concatenated with itself turns a plain shift into a rotate
  assign doubled  = {src1_i, src1_i};
  assign shl_wide = doubled << src2_i[3:0];
  assign shr_wide = doubled >> src2_i[3:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = src1_i + src2_i;
      OP_MUL:  result_o = src1_i * src2_i;
      OP_AND:  result_o = src1_i & src2_i;
      OP_OR:   result_o = src1_i | src2_i;
      OP_SHL:  result_o = shl_wide[2*REGISTER_SIZE-1:REGISTER_SIZE];
      OP_SHR:  result_o = shr_wide[REGISTER_SIZE-1:0];
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/processor_ram.sv
// Single-port synchronous RAM: read data appears the cycle after the address,
// writes land on the rising edge while write_enable is high.
module processor_ram
  import processor_pkg::*;
(
  input logic         i_clock,
  processor_if.slave  ram
);

  logic [INSTRUCTION_SIZE-1:0] memory [MEMORY_DEPTH];

  always_ff @(posedge i_clock) begin
    if (ram.write_enable) begin
      memory[ram.address] <= ram.write_data;
    end
    ram.read_data <= memory[ram.address];
  end

endmodule

// File: rtl/processor.sv
// Multi-cycle 16-bit load/store core: FETCH -> DECODE -> EXECUTE -> WRITE_BACK,
// sharing one RAM for code and data, stopping for good on the all-zero word.
module processor
  import processor_pkg::*;
(
  input  logic          i_clock,
  input  logic          i_reset,
  processor_if.master_rd read_ram,
  processor_if.master_wr write_ram
);

  logic [REGISTER_SIZE-1:0] registers [REGISTER_BANK_SIZE];

  state_e                          state_q;
  logic [MEMORY_ADDRESS_WIDTH-1:0] pc_q;
  logic [MEMORY_ADDRESS_WIDTH-1:0] address_q;
  instr_t                          instr_q;
  logic                            we_q;
  logic [REGISTER_SIZE-1:0]        wdata_q;
  logic [REGISTER_SIZE-1:0]        alu_q;
  logic [REGISTER_SIZE-1:0]        alu_result;
  instr_t                          fetched;
  logic                            rf_we;
  logic [REGISTER_SIZE-1:0]        rf_wdata;

  assign fetched                = instr_t'(read_ram.read_data);
  assign read_ram.address       = address_q;
  assign write_ram.write_enable = we_q;
  assign write_ram.write_data   = wdata_q;

  processor_alu u_alu (
    .op_i     (instr_q.op),
    .src1_i   (registers[instr_q.low[7:4]]),
    .src2_i   (registers[instr_q.low[3:0]]),
    .result_o (alu_result)
  );

  // Bus outputs are registered, so each state loads what the following state presents
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      address_q <= '0;
      instr_q   <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      alu_q     <= '0;
    end else begin
      case (state_q)
        ST_FETCH: state_q <= ST_DECODE;
        ST_DECODE: begin
          instr_q <= fetched;
          if (fetched == '0) begin
            state_q <= ST_HALT;
          end else begin
            state_q <= ST_EXECUTE;
            if (fetched.is_imm && fetched.op == OP_SW) begin
              address_q <= fetched.low;
              we_q      <= 1'b1;
              wdata_q   <= registers[fetched.rd];
            end else if (fetched.is_imm && fetched.op == OP_LW) begin
              address_q <= fetched.low;
            end
          end
        end
        ST_EXECUTE: begin
          we_q    <= 1'b0;
          alu_q   <= alu_result;
          state_q <= ST_WRITE_BACK;
        end
        ST_WRITE_BACK: begin
          pc_q      <= pc_q + 1'b1;
          address_q <= pc_q + 1'b1;
          state_q   <= ST_FETCH;
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  // Immediate ALU ops and register-form LW/SW fall through here as no-ops
  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = alu_q;
    if (state_q == ST_WRITE_BACK) begin
      if (!instr_q.is_imm && instr_q.op < OP_LW) begin
        rf_we = 1'b1;
      end else if (instr_q.is_imm && instr_q.op == OP_LW) begin
        rf_we    = 1'b1;
        rf_wdata = read_ram.read_data;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (rf_we) begin
      registers[instr_q.rd] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_processor.sv
// Bench for processor: an instruction-level interpreter predicts PC, registers
// and RAM after every instruction for directed and random programs.
module tb_processor;
  import processor_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  processor_if bus ();

  processor dut (
    .i_clock   (clk),
    .i_reset   (rst_n),
    .read_ram  (bus),
    .write_ram (bus)
  );

  processor_ram ram (
    .i_clock (clk),
    .ram     (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [15:0] m_mem [256];
  logic [15:0] m_reg [16];
  int          m_pc;
  bit          m_halt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc_r(int op, int rd, int rs1, int rs2);
    return {3'(op), 1'b0, 4'(rd), 4'(rs1), 4'(rs2)};
  endfunction

  function automatic logic [15:0] enc_i(int op, int rd, int adr);
    return {3'(op), 1'b1, 4'(rd), 8'(adr)};
  endfunction

  function automatic logic [15:0] rot(logic [15:0] v, int n, bit left);
    for (int k = 0; k < n; k++) v = left ? {v[14:0], v[15]} : {v[0], v[15:1]};
    return v;
  endfunction

  // One architectural instruction, straight from the ISA rules
  function automatic void m_step();
    logic [15:0] w;
    logic [15:0] a;
    logic [15:0] b;
    int op;
    int rd;
    int adr;
    bit imm;
    if (m_halt) return;
    w = m_mem[m_pc];
    if (w == 16'h0000) begin
      m_halt = 1'b1;
      return;
    end
    op  = int'(w[15:13]);
    imm = w[12];
    rd  = int'(w[11:8]);
    adr = int'(w[7:0]);
    a   = m_reg[w[7:4]];
    b   = m_reg[w[3:0]];
    if (!imm) begin
      case (op)
        0: m_reg[rd] = 16'((int'(a) + int'(b)) % 65536);
        1: m_reg[rd] = 16'((longint'(a) * longint'(b)) % 65536);
        2: m_reg[rd] = a & b;
        3: m_reg[rd] = a | b;
        4: m_reg[rd] = rot(a, int'(b) % 16, 1'b1);
        5: m_reg[rd] = rot(a, int'(b) % 16, 1'b0);
        default: ;
      endcase
    end else begin
      if (op == 6) m_reg[rd] = m_mem[adr];
      if (op == 7) m_mem[adr] = m_reg[rd];
    end
    m_pc = (m_pc + 1) % 256;
  endfunction

  task automatic load_and_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset/pc", 16'(dut.pc_q), 16'h0000);
    chk("reset/we", 16'(bus.write_enable), 16'h0000);
    chk("reset/addr", 16'(bus.address), 16'h0000);
    chk("reset/wdata", bus.write_data, 16'h0000);
    chk("reset/ir", 16'(dut.instr_q), 16'h0000);
    for (int i = 0; i < 256; i++) ram.memory[i] = m_mem[i];
    for (int i = 0; i < 16; i++) dut.registers[i] = m_reg[i];
    m_pc = 0;
    m_halt = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic exec_one(input string tag);
    logic [15:0] w;
    int rd;
    bit is_sw;
    w = m_mem[m_pc];
    rd = int'(w[11:8]);
    is_sw = !m_halt && w[15:13] == 3'd7 && w[12];
    m_step();
    repeat (4) @(posedge clk);
    #1;
    chk($sformatf("%s/pc", tag), 16'(dut.pc_q), 16'(m_pc));
    chk($sformatf("%s/r%0d", tag, rd), dut.registers[rd], m_reg[rd]);
    if (is_sw) chk($sformatf("%s/mem%0d", tag, w[7:0]), ram.memory[w[7:0]], m_mem[w[7:0]]);
  endtask

  task automatic full_compare(input string tag);
    for (int i = 0; i < 16; i++) chk($sformatf("%s/r%0d", tag, i), dut.registers[i], m_reg[i]);
    for (int i = 0; i < 256; i++) chk($sformatf("%s/mem%0d", tag, i), ram.memory[i], m_mem[i]);
  endtask

  initial begin
    // Directed program
    for (int i = 0; i < 256; i++) m_mem[i] = 16'($urandom_range(1, 65535));
    for (int i = 0; i < 16; i++) m_reg[i] = 16'($urandom);
    m_mem[0]  = enc_i(6, 1, 101);
    m_mem[1]  = enc_r(0, 2, 1, 1);
    m_mem[2]  = enc_i(7, 2, 255);
    m_mem[3]  = enc_r(1, 3, 2, 2);
    m_mem[4]  = enc_i(6, 2, 102);
    m_mem[5]  = enc_r(1, 3, 2, 2);
    m_mem[6]  = enc_i(6, 3, 103);
    m_mem[7]  = enc_r(4, 4, 3, 1);
    m_mem[8]  = enc_r(5, 5, 3, 1);
    m_mem[9]  = enc_i(6, 9, 104);
    m_mem[10] = enc_r(4, 10, 3, 9);
    m_mem[11] = enc_r(2, 15, 15, 15);
    m_mem[12] = enc_r(3, 15, 15, 15);
    m_mem[13] = enc_r(3, 6, 7, 8);
    m_mem[14] = enc_i(0, 11, 5);
    m_mem[15] = enc_r(6, 12, 1, 2);
    m_mem[16] = enc_r(7, 2, 0, 0);
    m_mem[17] = enc_r(5, 13, 3, 9);
    for (int i = 18; i < 26; i++)
      m_mem[i] = enc_r($urandom_range(0, 5), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    m_mem[26]  = 16'h0000;
    m_mem[101] = 16'h0001;
    m_mem[102] = 16'h0100;
    m_mem[103] = 16'h8001;
    m_mem[104] = 16'h0010;
    load_and_reset();
    for (int s = 0; s < 27; s++) begin
      exec_one($sformatf("dir%0d", s));
      case (s)
        0:  chk("lw_r1", dut.registers[1], 16'h0001);
        1:  chk("add_r2", dut.registers[2], 16'h0002);
        2:  chk("sw_mem255", ram.memory[255], 16'h0002);
        3:  chk("mul_r3", dut.registers[3], 16'h0004);
        5:  chk("mul_trunc", dut.registers[3], 16'h0000);
        7:  chk("shl_r4", dut.registers[4], 16'h0003);
        8:  chk("shr_r5", dut.registers[5], 16'hC000);
        10: chk("shl16_r10", dut.registers[10], 16'h8001);
        13: chk("or_r6", dut.registers[6], m_reg[7] | m_reg[8]);
        17: chk("shr16_r13", dut.registers[13], 16'h8001);
        default: ;
      endcase
    end
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("halt_we%0d", c), 16'(bus.write_enable), 16'h0000);
    end
    chk("halt/pc", 16'(dut.pc_q), 16'd26);
    full_compare("halt");

    // Reset asserted mid-EXECUTE of a store
    m_reg[2] = 16'hBEEF;
    m_mem[0] = enc_i(7, 2, 200);
    m_mem[200] = 16'h1234;
    load_and_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("sw_exec/we", 16'(bus.write_enable), 16'h0001);
    chk("sw_exec/addr", 16'(bus.address), 16'd200);
    chk("sw_exec/wdata", bus.write_data, 16'hBEEF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort/we", 16'(bus.write_enable), 16'h0000);
    chk("abort/pc", 16'(dut.pc_q), 16'h0000);
    m_mem[0] = 16'h0000;
    ram.memory[0] = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort/mem200", ram.memory[200], 16'h1234);
    chk("abort/pc_after", 16'(dut.pc_q), 16'h0000);

    // Random programs, long enough for the PC to wrap past 255
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++) begin
        int op;
        bit imm;
        op = $urandom_range(0, 7);
        imm = (op >= 6) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
        m_mem[i] = {3'(op), imm, 12'($urandom)};
      end
      for (int i = 0; i < 16; i++) m_reg[i] = 16'($urandom);
      load_and_reset();
      for (int s = 0; s < 300; s++) exec_one($sformatf("rnd%0d_%0d", r, s));
      full_compare($sformatf("rnd%0d_end", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
